// File: rtl/lsu_bus_if.sv
// Load/store unit between the MEM stage and a variable-latency data bus:
// request/ack handshake, byte strobes, load extension, misalignment and timeout.
module lsu_bus_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  stall,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  bus_req,
  output logic                  bus_wen,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int NB   = DATA_W / 8;
  localparam int LB   = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam int SH_B = DATA_W - 8;
  localparam int SH_H = DATA_W - 16;
  localparam int SH_W = DATA_W - 32;

  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_BUSY = 1'b1;
  localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT);

  logic [0:0]        state_r;
  logic [CW-1:0]     cnt_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic              we_r;
  logic [LB-1:0]     lane_r;
  logic [4:0]        rd_r;
  logic              bus_req_r;
  logic              bus_wen_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [NB-1:0]     bus_wstrb_r;
  logic [DATA_W-1:0] bus_wdata_r;

  logic              mis_s;
  logic [LB-1:0]     lane_s;
  logic [NB-1:0]     strb_s;
  logic [DATA_W-1:0] wdata_s;
  logic [6:0]        amt_s;
  logic [DATA_W-1:0] sh_s;
  logic [DATA_W-1:0] tmp_s;
  logic [DATA_W-1:0] ext_s;
  logic              stall_s;
  logic              rv_s;
  logic              rerr_s;
  logic [DATA_W-1:0] rdata_s;
  logic              accept_s;
  logic              done_s;

  assign lane_s = req_addr[LB-1:0];

  // Alignment check on the incoming request
  always_comb begin
    mis_s = 1'b0;
    case (req_size)
      2'b00:   mis_s = 1'b0;
      2'b01:   mis_s = req_addr[0];
      2'b10:   mis_s = (req_addr[1:0] != 2'b00);
      2'b11:   mis_s = (DATA_W == 32) ? 1'b1 : (req_addr[2:0] != 3'b000);
      default: mis_s = 1'b1;
    endcase
  end

  // Byte strobes and lane-replicated store data
  always_comb begin
    strb_s  = {NB{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    case (req_size)
      2'b00: begin
        strb_s  = NB'(1'b1) << lane_s;
        wdata_s = {NB{req_wdata[7:0]}};
      end
      2'b01: begin
        strb_s  = NB'(2'b11) << lane_s;
        wdata_s = {(NB/2){req_wdata[15:0]}};
      end
      2'b10: begin
        strb_s  = NB'(4'hF) << lane_s;
        wdata_s = {(NB/4){req_wdata[31:0]}};
      end
      default: begin
        strb_s  = {NB{1'b1}};
        wdata_s = req_wdata;
      end
    endcase
  end

  // Lane select then extend: push the field to the top, shift back down with fill
  always_comb begin
    amt_s = 7'd0;
    case (size_r)
      2'b00:   amt_s = 7'(SH_B);
      2'b01:   amt_s = 7'(SH_H);
      2'b10:   amt_s = 7'(SH_W);
      default: amt_s = 7'd0;
    endcase
    sh_s  = bus_rdata >> {lane_r, 3'b000};
    tmp_s = sh_s << amt_s;
    if (!uns_r && tmp_s[DATA_W-1]) begin
      ext_s = (tmp_s >> amt_s) | ~({DATA_W{1'b1}} >> amt_s);
    end else begin
      ext_s = tmp_s >> amt_s;
    end
  end

  // Handshake decode: stall, response pulse and state-change requests
  always_comb begin
    stall_s  = 1'b0;
    rv_s     = 1'b0;
    rerr_s   = 1'b0;
    rdata_s  = {DATA_W{1'b0}};
    accept_s = 1'b0;
    done_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req_valid && mis_s) begin
        rv_s   = 1'b1;
        rerr_s = 1'b1;
      end else if (req_valid) begin
        stall_s  = 1'b1;
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
    end else begin
      if (bus_ack) begin
        rv_s    = 1'b1;
        done_s  = 1'b1;
        rdata_s = we_r ? {DATA_W{1'b0}} : ext_s;
      end else if (cnt_r == TO_C) begin
        rv_s   = 1'b1;
        rerr_s = 1'b1;
        done_s = 1'b1;
      end else begin
        stall_s = 1'b1;
      end
    end
  end

  // Transaction state, wait counter and bus drive registers
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      size_r      <= 2'b00;
      uns_r       <= 1'b0;
      we_r        <= 1'b0;
      lane_r      <= {LB{1'b0}};
      rd_r        <= 5'd0;
      bus_req_r   <= 1'b0;
      bus_wen_r   <= 1'b0;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_wstrb_r <= {NB{1'b0}};
      bus_wdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      state_r     <= ST_BUSY;
      cnt_r       <= {CW{1'b0}};
      size_r      <= req_size;
      uns_r       <= req_unsigned;
      we_r        <= req_we;
      lane_r      <= lane_s;
      rd_r        <= req_rd;
      bus_req_r   <= 1'b1;
      bus_wen_r   <= req_we;
      bus_addr_r  <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
      bus_wstrb_r <= strb_s;
      bus_wdata_r <= wdata_s;
    end else if (done_s) begin
      state_r   <= ST_IDLE;
      bus_req_r <= 1'b0;
    end else if (state_r == ST_BUSY) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall      = stall_s;
  assign resp_valid = rv_s;
  assign resp_err   = rerr_s;
  assign resp_rdata = rdata_s;
  assign resp_rd    = rd_r;
  assign bus_req    = bus_req_r;
  assign bus_wen    = bus_wen_r;
  assign bus_addr   = bus_addr_r;
  assign bus_wstrb  = bus_wstrb_r;
  assign bus_wdata  = bus_wdata_r;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if (DATA_W=32, TIMEOUT=15): directed table, reset/timeout
// sequences and random transactions checked against a transaction-level model.
module tb_lsu_bus_if;

  localparam int TIMEOUT = 15;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        bus_req, bus_wen;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_vec = 0;
  int n_bad = 0;

  lsu_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall(stall), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd), .bus_req(bus_req),
    .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          dly;     // ack arrives dly cycles after bus_req rises; >TIMEOUT means never
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected results straight from the access rules, using plain arithmetic
  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    int     nb = 1 << v.size;
    int     lane = int'(v.addr % 4);
    longint val;
    r.mis    = (v.size == 2'b11) || ((v.addr % nb) != 0);
    r.e_addr = v.addr - (v.addr % 4);
    r.e_strb = 4'(((1 << nb) - 1) << lane);
    case (nb)
      1:       r.e_wdata = v.wdata[7:0] * 32'h0101_0101;
      2:       r.e_wdata = v.wdata[15:0] * 32'h0001_0001;
      default: r.e_wdata = v.wdata;
    endcase
    val = (longint'(v.rdata) >> (8 * lane)) & ((64'd1 << (8 * nb)) - 64'd1);
    if (!v.uns && (((val >> (8 * nb - 1)) & 64'd1) == 64'd1))
      val = val - (64'sd1 <<< (8 * nb));
    r.e_err   = r.mis || (v.dly > TIMEOUT);
    r.e_rdata = (v.we || r.e_err) ? 32'h0 : 32'(val);
    return r;
  endfunction

  task automatic drive_req(input vec_t v);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd; bus_ack = 1'b0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_txn(input vec_t v, input bit b2b);
    bit done = 0;
    bit exp_resp;
    drive_req(v);
    @(negedge cpu_clk);
    if (v.mis) begin
      chk("mis_valid", resp_valid, 1'b1);
      chk("mis_err", resp_err, 1'b1);
      chk("mis_stall", stall, 1'b0);
      chk("mis_rdata", resp_rdata, 32'h0);
      chk("mis_busreq", bus_req, 1'b0);
      @(posedge cpu_clk); #1;
    end else begin
      chk("req_stall", stall, 1'b1);
      chk("req_valid0", resp_valid, 1'b0);
      @(posedge cpu_clk); #1;
      for (int j = 0; j <= TIMEOUT + 2; j++) begin
        bus_ack   = (j == v.dly);
        bus_rdata = (j == v.dly) ? v.rdata : $urandom;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        @(negedge cpu_clk);
        if (j == 0) begin
          chk("bus_addr", bus_addr, v.e_addr);
          chk("bus_wstrb", bus_wstrb, v.e_strb);
          chk("bus_wen", bus_wen, v.we);
          if (v.we) chk("bus_wdata", bus_wdata, v.e_wdata);
        end
        exp_resp = (v.dly <= TIMEOUT) ? (j == v.dly) : (j == TIMEOUT);
        if (exp_resp) begin
          chk("resp_valid", resp_valid, 1'b1);
          chk("resp_err", resp_err, v.e_err);
          chk("resp_rdata", resp_rdata, v.e_rdata);
          chk("resp_stall", stall, 1'b0);
          if (!v.e_err) chk("resp_rd", resp_rd, v.rd);
          done = 1;
        end else begin
          chk("wait_stall", stall, 1'b1);
          chk("wait_valid", resp_valid, 1'b0);
          chk("wait_busreq", bus_req, 1'b1);
        end
        @(posedge cpu_clk); #1;
        if (done) break;
      end
    end
    bus_ack = (v.dly > TIMEOUT) && !v.mis;  // late ack after a timeout must be ignored
    if (!b2b || bus_ack) begin
      req_valid = 1'b0;
      @(negedge cpu_clk);
      chk("post_busreq", bus_req, 1'b0);
      chk("post_valid", resp_valid, 1'b0);
      @(posedge cpu_clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1, 0, 32'h0,
                1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 5'd7, 3, 32'h80FF_0000,
                1'b0, 32'h200, 4'h8, 32'h0, 1'b0, 32'hFFFF_FF80};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 5'd8, 3, 32'h80FF_0000,
                1'b0, 32'h200, 4'h8, 32'h0, 1'b0, 32'h0000_0080};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_1234, 5'd2, 1, 32'h0,
                1'b0, 32'h300, 4'hC, 32'h1234_1234, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd3, 0, 32'h0,
                1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00A5, 5'd4, 2, 32'h0,
                1'b0, 32'h40, 4'h2, 32'hA5A5_A5A5, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 5'd5, 0, 32'h1234_8001,
                1'b0, 32'h10, 4'h3, 32'h0, 1'b0, 32'hFFFF_8001};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 5'd6, 0, 32'h8001_7FFF,
                1'b0, 32'h10, 4'hC, 32'h0, 1'b0, 32'h0000_8001};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 5'd9, 0, 32'h0,
                1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd10, 99, 32'h0,
                1'b0, 32'h400, 4'hF, 32'h0, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h3, 32'h0, 5'd11, 0, 32'h0,
                1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 5'd12, 5, 32'h0000_7F00,
                1'b0, 32'h0, 4'h2, 32'h0, 1'b0, 32'h0000_007F};

    cpu_rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_busreq", bus_req, 1'b0);
    chk("rst_wen", bus_wen, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wstrb", bus_wstrb, 4'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rd", resp_rd, 5'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_valid", resp_valid, 1'b0);
    @(negedge cpu_clk); cpu_rst = 1'b1;
    @(posedge cpu_clk); #1;

    for (int i = 0; i < 12; i++) run_txn(tbl[i], 1'b0);

    // Reset asserted in the second BUSY cycle aborts the access silently
    v = tbl[1];
    drive_req(v);
    @(posedge cpu_clk); #1;
    @(posedge cpu_clk); #1;
    req_valid = 1'b0;
    cpu_rst = 1'b0;
    #1;
    chk("abort_busreq", bus_req, 1'b0);
    chk("abort_valid", resp_valid, 1'b0);
    chk("abort_wstrb", bus_wstrb, 4'h0);
    chk("abort_rd", resp_rd, 5'd0);
    @(negedge cpu_clk); cpu_rst = 1'b1;
    @(posedge cpu_clk); #1;
    run_txn(tbl[2], 1'b0);

    for (int i = 0; i < 150; i++) begin
      v.we = 1'($urandom); v.size = 2'($urandom); v.uns = 1'($urandom);
      v.addr = $urandom; v.wdata = $urandom; v.rd = 5'($urandom);
      v.dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 3))
                                          : int'($urandom_range(0, 3));
      v.rdata = $urandom;
      run_txn(model(v), 1'($urandom));
    end

    req_valid = 1'b0;
    @(posedge cpu_clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_if.md
# lsu_bus_if

Parametrised load/store unit bridging the MEM stage of the pipelined core to a variable-latency data bus. Replaces the fixed single-cycle bus drive (address, write-enable, write-data straight from the MEM register) with a request/acknowledge handshake, sub-word byte strobes, load sign/zero extension, misalignment detection, a timeout, and a pipeline stall output. Sits between the EX/MEM pipeline register and the bridge; its response feeds the MEM/WB register.

## Interface
- DATA_W, 32: data bus width; 32 or 64 only. NB = DATA_W/8 lanes, LB = log2(NB).
- ADDR_W, 32: address width.
- TIMEOUT, 15: maximum wait cycles for `bus_ack` after `bus_req` rises; ≥1.
- cpu_clk  in  1  clock; all state changes on the rising edge.
- cpu_rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load/store; held stable while `stall`=1.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, value in the low bits.
- req_rd  in  5  load destination register, echoed on response.
- stall  out  1  freeze IF..MEM this cycle (combinational).
- resp_valid  out  1  one-cycle completion pulse (combinational).
- resp_err  out  1  qualifies `resp_valid`: misaligned or timed out.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_rd  out  5  latched `req_rd`.
- bus_req  out  1  transaction active (registered).
- bus_wen  out  1  write (registered).
- bus_addr  out  ADDR_W  lane-aligned address, low LB bits forced to 0 (registered).
- bus_wstrb  out  NB  byte enables (registered).
- bus_wdata  out  DATA_W  lane-replicated store data (registered).
- bus_ack  in  1  completion; sampled only while `bus_req`=1.
- bus_rdata  in  DATA_W  read data, valid in the `bus_ack` cycle.

## Operation
- States: IDLE, BUSY.
- Alignment: misaligned when half && addr[0]!=0, word && addr[1:0]!=0, double && addr[2:0]!=0, or size 11 with DATA_W=32.
- IDLE, req_valid, misaligned: no bus activity; same cycle resp_valid=1, resp_err=1, resp_rdata=0, stall=0; stay IDLE.
- IDLE, req_valid, aligned: stall=1; on the edge, latch size/unsigned/lane/rd, load bus_* registers, bus_req←1, clear wait counter, go BUSY.
- Strobes: byte → 1<<lane; half → 2'b11<<lane; word → 4'hF<<lane; double → all ones. Loads drive the same strobes, bus_wen=0.
- Write data: byte replicated NB times, half replicated NB/2 times, word replicated NB/4 times.
- BUSY, bus_ack=1: resp_valid=1, resp_err=0, stall=0; resp_rdata = selected lane bytes of bus_rdata, extended to DATA_W (stores: 0); on the edge bus_req←0, go IDLE.
- BUSY, bus_ack=0, counter<TIMEOUT: stall=1, counter+1 (saturating width clog2(TIMEOUT+1)).
- BUSY, bus_ack=0, counter==TIMEOUT: resp_valid=1, resp_err=1, resp_rdata=0, stall=0; bus_req←0, go IDLE. A late ack is ignored (bus_req low).
- req_* inputs ignored in BUSY; latched copies drive response formatting.
- resp_valid=0 ⇒ resp_err=0, resp_rdata=0.

## Timing
- Reset (async assert): state IDLE, bus_req/bus_wen/bus_addr/bus_wstrb/bus_wdata/counter=0, resp_rd=0; combinational outputs follow IDLE rules. Reset mid-BUSY drops bus_req immediately, no response.
- Minimum access: request cycle T (stall=1), bus_req high T+1; ack at T+1 gives resp_valid at T+1 with stall=0 — one stall cycle.
- Ack at T+k: stall high T..T+k-1, resp_valid at T+k.
- Timeout: ack never arrives → resp_err pulse at T+1+TIMEOUT.
- Back-to-back: new req_valid in the cycle after resp_valid is accepted from IDLE; bus_req low for at least one cycle between transactions.

## Test plan
- Word store 0xDEADBEEF to 0x100, ack at T+1 → bus_addr=0x100, bus_wstrb=4'hF, bus_wen=1 at T+1; stall 1 only at T; resp_valid at T+1, resp_rdata=0.
- Signed byte load from 0x203, bus_rdata=0x80FF_0000, ack after 3 waits → bus_wstrb=4'b1000, stall 4 cycles, resp_rdata=0xFFFF_FF80, resp_rd echoed; unsigned repeat → 0x0000_0080.
- Half store 0x1234 to 0x302 → bus_addr=0x300, bus_wstrb=4'b1100, bus_wdata=0x1234_1234.
- Word load from 0x101 → resp_valid+resp_err same cycle, stall=0, bus_req never rises.
- No ack, TIMEOUT=15 → resp_err at T+16, bus_req falls; ack at T+17 ignored, no second response.
- cpu_rst low during BUSY (cycle T+2) → bus_req=0 immediately, resp_valid=0; after release, next aligned load completes normally.
